wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter. It shares a single memory (mem_bram) between the cpu bus master (M0: instruction fetch and load/store) and a second master (M1: program loader or debug port).
- Accepts single-cycle strobe pulses from either master and buffers one colliding request.
- Issues one transaction at a time to the slave and routes the ack and read data back to the originating master.
- Sits between the cpu's o_wb_* port and the memory's i_wb_* port.

Parameters:
- ADDR_W, 32, address width for both masters and the slave.
- DATA_W, 32, data width.
- SEL_W, 3, width of the access-size select field (funct3 encoding), passed through unchanged.
- TIMEOUT_CYCLES, 255, slave-ack timeout; used only when ARB_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_m0_wb_stb  in  1  M0 request strobe (single-cycle pulse)
- i_m0_wb_we  in  1  M0 write enable
- i_m0_wb_addr  in  ADDR_W  M0 address
- i_m0_wb_data  in  DATA_W  M0 write data
- i_m0_wb_sel  in  SEL_W  M0 size select
- o_m0_wb_data  out  DATA_W  read data to M0
- o_m0_wb_ack  out  1  completion pulse to M0
- o_m0_wb_stall  out  1  M0 must not strobe while high
- i_m1_wb_*, o_m1_wb_*  same set as M0, for M1
- o_s_wb_stb  out  1  slave strobe
- o_s_wb_we  out  1  slave write enable
- o_s_wb_addr  out  ADDR_W  slave address
- o_s_wb_data  out  DATA_W  slave write data
- o_s_wb_sel  out  SEL_W  slave size select
- i_s_wb_data  in  DATA_W  slave read data
- i_s_wb_ack  in  1  slave completion
- i_s_wb_stall  in  1  slave busy
- o_err  out  1  timeout flag (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset (async, i_reset_n=0):
  - All outputs 0: stb/ack/stall/we/err; addr, data and sel are 0.
  - state=S_IDLE, pending_valid=0, last_grant=1, so M0 wins the first tie.
- All outputs are registered. Masters are internally stalled outside S_IDLE and while pending_valid=1.
- S_IDLE:
  - If pending_valid: promote pending to active, clear pending_valid, go S_ISSUE.
  - Else if exactly one stb: capture that master's we/addr/data/sel and grant_id, assert both stalls, go S_ISSUE.
  - Else if both stb in the same cycle: the winner is the master not equal to last_grant. Capture the winner as active and the loser into the pending buffer (pending_valid=1). Assert both stalls, go S_ISSUE.
- S_ISSUE: if !i_s_wb_stall, drive o_s_wb_stb=1 for exactly one cycle with the active fields and go S_WAIT_ACK. Otherwise hold.
- S_WAIT_ACK:
  - o_s_wb_stb<=0.
  - On i_s_wb_ack: latch i_s_wb_data and go S_RESP.
  - An ack arriving in the same cycle as the stb is treated identically.
- S_RESP:
  - Pulse o_mX_wb_ack=1 for one cycle to grant_id only, with o_mX_wb_data = latched data. The other master's ack stays 0 and its data is unchanged.
  - Set last_grant=grant_id.
  - If pending_valid: promote pending, go S_ISSUE, stalls stay 1.
  - Else go S_IDLE and deassert both stalls.
- Latency:
  - Accepted strobe at cycle t gives slave stb at t+1 if the slave is not stalled.
  - Slave ack at cycle a gives master ack at a+1.
- A strobe from either master while its stall=1 is a protocol violation and is ignored. It must not corrupt the active or pending request.
- Write data to the slave is passed as-is; sel is passed unchanged with no byte masking.
- Reset mid-transaction: immediate return to reset values. Any pending request is dropped and no ack is issued.
- Unreachable state: return to S_IDLE and deassert stb and ack.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined, a counter runs in S_WAIT_ACK. On reaching TIMEOUT_CYCLES with no ack:
  - Go S_RESP with data 32'hFFFFFFFF.
  - Set o_err=1, sticky until reset.
  - The master still receives its single ack pulse.
- When undefined: no counter, o_err tied 0, and S_WAIT_ACK waits indefinitely.

Test Plan:
- M0 read, addr 0x10, slave acks 1 cycle after stb with 0xDEADBEEF -> o_s_wb_stb pulse at t+1; o_m0_wb_ack at ack+1 with data 0xDEADBEEF; o_m1_wb_ack stays 0.
- M0 and M1 strobe in the same cycle after reset (M0 read 0x0, M1 write 0x55 to 0x20) -> M0 served first. M1 is issued from pending without any re-strobe; exactly one ack each, in order M0 then M1.
- Back-to-back tie again after M0 was served -> M1 wins (round-robin); M0 is served second.
- i_s_wb_stall held high 5 cycles in S_ISSUE -> o_s_wb_stb held off, then asserted exactly one cycle once the stall drops.
- Reset asserted in S_WAIT_ACK with a pending request -> all outputs 0 immediately. No ack after release; the next M1 request completes normally.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> after 8 cycles M0 gets an ack with 0xFFFFFFFF and o_err=1 stays high.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone arbiter: round-robin tie-break, one-deep collision buffer.
// Optional slave-ack timeout with sticky o_err is enabled by defining ARB_TIMEOUT_EN.
module wb_bus_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned SEL_W          = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_m0_wb_stb,
  input  logic              i_m0_wb_we,
  input  logic [ADDR_W-1:0] i_m0_wb_addr,
  input  logic [DATA_W-1:0] i_m0_wb_data,
  input  logic [SEL_W-1:0]  i_m0_wb_sel,
  output logic [DATA_W-1:0] o_m0_wb_data,
  output logic              o_m0_wb_ack,
  output logic              o_m0_wb_stall,
  input  logic              i_m1_wb_stb,
  input  logic              i_m1_wb_we,
  input  logic [ADDR_W-1:0] i_m1_wb_addr,
  input  logic [DATA_W-1:0] i_m1_wb_data,
  input  logic [SEL_W-1:0]  i_m1_wb_sel,
  output logic [DATA_W-1:0] o_m1_wb_data,
  output logic              o_m1_wb_ack,
  output logic              o_m1_wb_stall,
  output logic              o_s_wb_stb,
  output logic              o_s_wb_we,
  output logic [ADDR_W-1:0] o_s_wb_addr,
  output logic [DATA_W-1:0] o_s_wb_data,
  output logic [SEL_W-1:0]  o_s_wb_sel,
  input  logic [DATA_W-1:0] i_s_wb_data,
  input  logic              i_s_wb_ack,
  input  logic              i_s_wb_stall,
  output logic              o_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StResp} state_e;

  state_e            state_q;
  logic              grant_id_q, last_grant_q;
  logic              pend_valid_q, pend_id_q, pend_we_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_data_q;
  logic [SEL_W-1:0]  pend_sel_q;
  logic [DATA_W-1:0] resp_data_q;

  logic              both_stb, any_stb;
  logic              win_id, win_we, lose_we;
  logic [ADDR_W-1:0] win_addr, lose_addr;
  logic [DATA_W-1:0] win_data, lose_data;
  logic [SEL_W-1:0]  win_sel, lose_sel;
  logic              nxt_id, nxt_we;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_data;
  logic [SEL_W-1:0]  nxt_sel;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_cnt_q;
  logic            err_q;
  assign o_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign o_err = 1'b0;
`endif

  // On a tie the master that was not served last wins; a buffered request always goes first.
  always_comb begin
    both_stb = i_m0_wb_stb & i_m1_wb_stb;
    any_stb  = i_m0_wb_stb | i_m1_wb_stb;
    win_id   = both_stb ? ~last_grant_q : i_m1_wb_stb;
    if (win_id) begin
      win_we  = i_m1_wb_we;   win_addr  = i_m1_wb_addr; win_data  = i_m1_wb_data;
      win_sel = i_m1_wb_sel;
      lose_we = i_m0_wb_we;   lose_addr = i_m0_wb_addr; lose_data = i_m0_wb_data;
      lose_sel = i_m0_wb_sel;
    end else begin
      win_we  = i_m0_wb_we;   win_addr  = i_m0_wb_addr; win_data  = i_m0_wb_data;
      win_sel = i_m0_wb_sel;
      lose_we = i_m1_wb_we;   lose_addr = i_m1_wb_addr; lose_data = i_m1_wb_data;
      lose_sel = i_m1_wb_sel;
    end
    if (pend_valid_q) begin
      nxt_id = pend_id_q; nxt_we = pend_we_q; nxt_addr = pend_addr_q;
      nxt_data = pend_data_q; nxt_sel = pend_sel_q;
    end else begin
      nxt_id = win_id; nxt_we = win_we; nxt_addr = win_addr;
      nxt_data = win_data; nxt_sel = win_sel;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= StIdle;
      grant_id_q    <= 1'b0;
      last_grant_q  <= 1'b1;
      pend_valid_q  <= 1'b0;
      pend_id_q     <= 1'b0;
      pend_we_q     <= 1'b0;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
      pend_sel_q    <= '0;
      resp_data_q   <= '0;
      o_s_wb_stb    <= 1'b0;
      o_s_wb_we     <= 1'b0;
      o_s_wb_addr   <= '0;
      o_s_wb_data   <= '0;
      o_s_wb_sel    <= '0;
      o_m0_wb_data  <= '0;
      o_m0_wb_ack   <= 1'b0;
      o_m0_wb_stall <= 1'b0;
      o_m1_wb_data  <= '0;
      o_m1_wb_ack   <= 1'b0;
      o_m1_wb_stall <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      o_s_wb_stb  <= 1'b0;
      o_m0_wb_ack <= 1'b0;
      o_m1_wb_ack <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pend_valid_q || any_stb) begin
            grant_id_q    <= nxt_id;
            o_s_wb_we     <= nxt_we;
            o_s_wb_addr   <= nxt_addr;
            o_s_wb_data   <= nxt_data;
            o_s_wb_sel    <= nxt_sel;
            o_m0_wb_stall <= 1'b1;
            o_m1_wb_stall <= 1'b1;
            state_q       <= StIssue;
            if (pend_valid_q) begin
              pend_valid_q <= 1'b0;
            end else if (both_stb) begin
              pend_valid_q <= 1'b1;
              pend_id_q    <= ~win_id;
              pend_we_q    <= lose_we;
              pend_addr_q  <= lose_addr;
              pend_data_q  <= lose_data;
              pend_sel_q   <= lose_sel;
            end
          end
        end
        StIssue: begin
          if (!i_s_wb_stall) begin
            o_s_wb_stb <= 1'b1;
            state_q    <= StWaitAck;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
          end
        end
        StWaitAck: begin
          if (i_s_wb_ack) begin
            resp_data_q <= i_s_wb_data;
            state_q     <= StResp;
`ifdef ARB_TIMEOUT_EN
          end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            resp_data_q <= '1;
            err_q       <= 1'b1;
            state_q     <= StResp;
          end else begin
            tmo_cnt_q   <= tmo_cnt_q + 1'b1;
`endif
          end
        end
        StResp: begin
          if (grant_id_q) begin
            o_m1_wb_ack  <= 1'b1;
            o_m1_wb_data <= resp_data_q;
          end else begin
            o_m0_wb_ack  <= 1'b1;
            o_m0_wb_data <= resp_data_q;
          end
          last_grant_q <= grant_id_q;
          if (pend_valid_q) begin
            grant_id_q   <= pend_id_q;
            o_s_wb_we    <= pend_we_q;
            o_s_wb_addr  <= pend_addr_q;
            o_s_wb_data  <= pend_data_q;
            o_s_wb_sel   <= pend_sel_q;
            pend_valid_q <= 1'b0;
            state_q      <= StIssue;
          end else begin
            o_m0_wb_stall <= 1'b0;
            o_m1_wb_stall <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed self-checking bench for wb_bus_arbiter; build with ARB_TIMEOUT_EN to cover the timeout.
module tb_wb_bus_arbiter;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        m0_stb = 0, m0_we = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [2:0]  m0_sel = '0, m1_sel = '0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_stall, m1_ack, m1_stall;
  logic        s_stb, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [2:0]  s_sel;
  logic [31:0] s_rdata = '0;
  logic        s_ack = 0, s_stall = 0;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .SEL_W(3), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m0_wb_stb(m0_stb), .i_m0_wb_we(m0_we), .i_m0_wb_addr(m0_addr),
    .i_m0_wb_data(m0_wdata), .i_m0_wb_sel(m0_sel), .o_m0_wb_data(m0_rdata),
    .o_m0_wb_ack(m0_ack), .o_m0_wb_stall(m0_stall),
    .i_m1_wb_stb(m1_stb), .i_m1_wb_we(m1_we), .i_m1_wb_addr(m1_addr),
    .i_m1_wb_data(m1_wdata), .i_m1_wb_sel(m1_sel), .o_m1_wb_data(m1_rdata),
    .o_m1_wb_ack(m1_ack), .o_m1_wb_stall(m1_stall),
    .o_s_wb_stb(s_stb), .o_s_wb_we(s_we), .o_s_wb_addr(s_addr), .o_s_wb_data(s_wdata),
    .o_s_wb_sel(s_sel), .i_s_wb_data(s_rdata), .i_s_wb_ack(s_ack), .i_s_wb_stall(s_stall),
    .o_err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    #2;
    n_checks++;
    if ((|{s_stb, s_we, s_addr, s_wdata, s_sel, m0_rdata, m0_ack, m0_stall,
           m1_rdata, m1_ack, m1_stall, err}) !== 1'b0) begin
      n_errors++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    end
    tick(); tick();
    rst_n = 1;
    tick(); tick();
    n_checks++;
    if ({s_stb, m0_stall, m1_stall, m0_ack, m1_ack, err} !== 6'b0) begin
      n_errors++; $display("FAIL idle_after_reset: got %b want 000000",
                           {s_stb, m0_stall, m1_stall, m0_ack, m1_ack, err});
    end
  endtask

  // M0 reads 0x0, M1 writes 0x55 to 0x20 in the same cycle; first_m1 says who should win.
  task automatic test_tie(input logic first_m1, input string tag);
    logic [31:0] a1, a2;
    logic        fa, sa, fo, so;
    a1 = first_m1 ? 32'h20 : 32'h0;
    a2 = first_m1 ? 32'h0 : 32'h20;
    m0_stb = 1; m0_we = 0; m0_addr = 32'h0;  m0_wdata = 32'h0;  m0_sel = 3'd2;
    m1_stb = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h55; m1_sel = 3'd2;
    tick();
    // Strobes while stalled must be ignored.
    m0_addr = 32'hBAD; m1_addr = 32'hBAD; m1_wdata = 32'hBAD;
    n_checks++;
    if ({m0_stall, m1_stall, s_stb} !== 3'b110) begin
      n_errors++; $display("FAIL %s stall_on_accept: got %b want 110", tag,
                           {m0_stall, m1_stall, s_stb});
    end
    tick();
    m0_stb = 0; m1_stb = 0;
    n_checks++;
    if ({s_stb, s_we, s_addr} !== {1'b1, first_m1, a1}) begin
      n_errors++; $display("FAIL %s first_issue: got stb=%b we=%b addr=%0h want 1 %b %0h",
                           tag, s_stb, s_we, s_addr, first_m1, a1);
    end
    if (first_m1) begin
      n_checks++;
      if (s_wdata !== 32'h55) begin
        n_errors++; $display("FAIL %s first_wdata: got %0h want 55", tag, s_wdata);
      end
    end
    s_ack = 1; s_rdata = 32'h1111_1111;  // ack in the same cycle as the strobe
    tick();
    s_ack = 0; s_rdata = '0;
    n_checks++;
    if ({s_stb, m0_ack, m1_ack} !== 3'b000) begin
      n_errors++; $display("FAIL %s stb_one_cycle: got %b want 000", tag, {s_stb, m0_ack, m1_ack});
    end
    tick();
    fa = first_m1 ? m1_ack : m0_ack;
    so = first_m1 ? m0_ack : m1_ack;
    n_checks++;
    if ({fa, so, m0_stall, m1_stall} !== 4'b1011) begin
      n_errors++; $display("FAIL %s first_ack: got ack=%b other=%b stalls=%b%b want 1 0 11",
                           tag, fa, so, m0_stall, m1_stall);
    end
    n_checks++;
    if ((first_m1 ? m1_rdata : m0_rdata) !== 32'h1111_1111) begin
      n_errors++; $display("FAIL %s first_rdata: got %0h want 11111111", tag,
                           first_m1 ? m1_rdata : m0_rdata);
    end
    tick();
    n_checks++;
    if ({s_stb, s_we, s_addr, m0_ack, m1_ack} !== {1'b1, ~first_m1, a2, 2'b00}) begin
      n_errors++; $display("FAIL %s second_issue: got stb=%b we=%b addr=%0h want 1 %b %0h",
                           tag, s_stb, s_we, s_addr, ~first_m1, a2);
    end
    if (!first_m1) begin
      n_checks++;
      if (s_wdata !== 32'h55) begin
        n_errors++; $display("FAIL %s second_wdata: got %0h want 55", tag, s_wdata);
      end
    end
    tick();
    s_ack = 1; s_rdata = 32'h2222_2222;
    tick();
    s_ack = 0; s_rdata = '0;
    tick();
    sa = first_m1 ? m0_ack : m1_ack;
    fo = first_m1 ? m1_ack : m0_ack;
    n_checks++;
    if ({sa, fo, m0_stall, m1_stall} !== 4'b1000) begin
      n_errors++; $display("FAIL %s second_ack: got ack=%b other=%b stalls=%b%b want 1 0 00",
                           tag, sa, fo, m0_stall, m1_stall);
    end
    n_checks++;
    if ((first_m1 ? m0_rdata : m1_rdata) !== 32'h2222_2222 ||
        (first_m1 ? m1_rdata : m0_rdata) !== 32'h1111_1111) begin
      n_errors++; $display("FAIL %s second_rdata: got m0=%0h m1=%0h", tag, m0_rdata, m1_rdata);
    end
    tick();
    n_checks++;
    if ({m0_ack, m1_ack, s_stb} !== 3'b000) begin
      n_errors++; $display("FAIL %s quiet_after: got %b want 000", tag, {m0_ack, m1_ack, s_stb});
    end
  endtask

  task automatic test_m0_read();
    m0_stb = 1; m0_we = 0; m0_addr = 32'h10; m0_sel = 3'd2;
    tick();
    m0_stb = 0;
    n_checks++;
    if (s_stb !== 1'b0) begin
      n_errors++; $display("FAIL rd_no_early_stb: got %b want 0", s_stb);
    end
    tick();
    n_checks++;
    if ({s_stb, s_we, s_addr, s_sel} !== {1'b1, 1'b0, 32'h10, 3'd2}) begin
      n_errors++; $display("FAIL rd_issue: got stb=%b we=%b addr=%0h sel=%0d want 1 0 10 2",
                           s_stb, s_we, s_addr, s_sel);
    end
    tick();
    s_ack = 1; s_rdata = 32'hDEAD_BEEF;
    tick();
    s_ack = 0; s_rdata = '0;
    n_checks++;
    if (m0_ack !== 1'b0) begin
      n_errors++; $display("FAIL rd_no_early_ack: got %b want 0", m0_ack);
    end
    tick();
    n_checks++;
    if ({m0_ack, m1_ack, m0_rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      n_errors++; $display("FAIL rd_ack: got m0_ack=%b m1_ack=%b data=%0h want 1 0 deadbeef",
                           m0_ack, m1_ack, m0_rdata);
    end
    tick();
    n_checks++;
    if ({m0_ack, m0_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
      n_errors++; $display("FAIL rd_ack_pulse: got ack=%b data=%0h want 0 deadbeef",
                           m0_ack, m0_rdata);
    end
  endtask

  task automatic test_slave_stall();
    int early;
    early = 0;
    s_stall = 1;
    m1_stb = 1; m1_we = 0; m1_addr = 32'h30; m1_sel = 3'd1;
    tick();
    m1_stb = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (s_stb !== 1'b0) early++;
    end
    n_checks++;
    if (early != 0) begin
      n_errors++; $display("FAIL stall_holdoff: got %0d stb cycles want 0", early);
    end
    s_stall = 0;
    tick();
    n_checks++;
    if ({s_stb, s_addr} !== {1'b1, 32'h30}) begin
      n_errors++; $display("FAIL stall_release: got stb=%b addr=%0h want 1 30", s_stb, s_addr);
    end
    tick();
    n_checks++;
    if (s_stb !== 1'b0) begin
      n_errors++; $display("FAIL stall_single_stb: got %b want 0", s_stb);
    end
    s_ack = 1; s_rdata = 32'h0000_3030;
    tick();
    s_ack = 0;
    tick();
    n_checks++;
    if ({m1_ack, m1_rdata} !== {1'b1, 32'h0000_3030}) begin
      n_errors++; $display("FAIL stall_ack: got ack=%b data=%0h want 1 3030", m1_ack, m1_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int spurious, cyc;
    spurious = 0;
    m0_stb = 1; m0_we = 0; m0_addr = 32'h4;
    m1_stb = 1; m1_we = 1; m1_addr = 32'h24; m1_wdata = 32'h77;
    tick();
    m0_stb = 0; m1_stb = 0;
    tick(); tick();
    rst_n = 0;
    #1;
    n_checks++;
    if ((|{s_stb, s_we, s_addr, s_wdata, s_sel, m0_rdata, m0_ack, m0_stall,
           m1_rdata, m1_ack, m1_stall, err}) !== 1'b0) begin
      n_errors++; $display("FAIL midreset_outputs: got nonzero outputs, want all 0");
    end
    tick(); tick();
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m0_ack || m1_ack || s_stb) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin
      n_errors++; $display("FAIL midreset_dropped: got %0d activity cycles want 0", spurious);
    end
    m1_stb = 1; m1_we = 0; m1_addr = 32'h40;
    tick();
    m1_stb = 0;
    cyc = 0;
    while (s_stb !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    n_checks++;
    if ({s_stb, s_addr} !== {1'b1, 32'h40}) begin
      n_errors++; $display("FAIL midreset_next_issue: got stb=%b addr=%0h want 1 40", s_stb, s_addr);
    end
    s_ack = 1; s_rdata = 32'hCAFE_F00D;
    tick();
    s_ack = 0;
    tick();
    n_checks++;
    if ({m1_ack, m0_ack, m1_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
      n_errors++; $display("FAIL midreset_next_ack: got m1=%b m0=%b data=%0h want 1 0 cafef00d",
                           m1_ack, m0_ack, m1_rdata);
    end
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    m0_stb = 1; m0_we = 0; m0_addr = 32'h50;
    tick();
    m0_stb = 0;
    tick();
    cyc = 0;
    while (m0_ack !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
    // TMO silent wait cycles, then one cycle in the response state.
    n_checks++;
    if (cyc != TMO + 1) begin
      n_errors++; $display("FAIL tmo_latency: got %0d cycles want %0d", cyc, TMO + 1);
    end
    n_checks++;
    if ({m0_ack, m0_rdata, err} !== {1'b1, 32'hFFFF_FFFF, 1'b1}) begin
      n_errors++; $display("FAIL tmo_ack: got ack=%b data=%0h err=%b want 1 ffffffff 1",
                           m0_ack, m0_rdata, err);
    end
    tick(); tick(); tick();
    n_checks++;
    if ({err, m0_ack} !== 2'b10) begin
      n_errors++; $display("FAIL tmo_err_sticky: got err=%b ack=%b want 1 0", err, m0_ack);
    end
  endtask
`else
  task automatic test_timeout();
    int acks;
    acks = 0;
    m0_stb = 1; m0_we = 0; m0_addr = 32'h50;
    tick();
    m0_stb = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m0_ack || err) acks++;
    end
    n_checks++;
    if (acks != 0 || m0_stall !== 1'b1) begin
      n_errors++; $display("FAIL notmo_wait: got %0d ack/err cycles stall=%b want 0 1",
                           acks, m0_stall);
    end
    s_ack = 1; s_rdata = 32'h5050_5050;
    tick();
    s_ack = 0;
    tick();
    n_checks++;
    if ({m0_ack, m0_rdata, err} !== {1'b1, 32'h5050_5050, 1'b0}) begin
      n_errors++; $display("FAIL notmo_ack: got ack=%b data=%0h err=%b want 1 50505050 0",
                           m0_ack, m0_rdata, err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tie(1'b0, "tie");
    test_m0_read();
    test_tie(1'b1, "b2b");
    test_slave_stall();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
